dds_sweep_ctrl: RTL and testbench

- Sequences the DDS frequency word through a linear sweep from a start word to a stop word, holding each step for a programmable dwell time.
- Dwell timing comes from an internal clock-enable prescaler on the 100 MHz system clock. No derived clocks are used; everything runs in the clk domain.
- The block sits between the board controls/configuration registers and the DDS phase accumulator, which consumes fword.

---
 rtl/dds_pkg.sv | 15 +
 rtl/dds_sweep_ctrl_if.sv | 31 +++
 rtl/dds_sweep_ctrl_tick_prescaler.sv | 29 ++
 rtl/dds_sweep_ctrl.sv | 144 ++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dds_pkg.sv
// Shared DDS definitions: sweep state encoding and default word widths.
// Also used by the phase accumulator and LUT blocks.
package dds_pkg;

   localparam int FW_W_DEF    = 32;
   localparam int DWELL_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DWELL = 2'd1,
      ST_STEP  = 2'd2,
      ST_DONE  = 2'd3
   } sweep_state_t;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Control/configuration bundle between the board controls and the sweep controller.
interface dds_sweep_ctrl_if
   import dds_pkg::*;
#(
   parameter int FW_W    = FW_W_DEF,
   parameter int DWELL_W = DWELL_W_DEF
) ();

   logic               start;
   logic               stop;
   logic               repeat_en;
   logic [FW_W-1:0]    f_start;
   logic [FW_W-1:0]    f_stop;
   logic [FW_W-1:0]    f_step;
   logic [DWELL_W-1:0] dwell;
   logic [FW_W-1:0]    fword;
   logic               fword_valid;
   logic               busy;
   logic               done;

   modport master (
      output start, stop, repeat_en, f_start, f_stop, f_step, dwell,
      input  fword, fword_valid, busy, done
   );

   modport slave (
      input  start, stop, repeat_en, f_start, f_stop, f_step, dwell,
      output fword, fword_valid, busy, done
   );

endinterface

// File: rtl/dds_sweep_ctrl_tick_prescaler.sv
// Clock-enable prescaler: one-cycle tick every DIV enabled cycles, no derived clocks.
module tick_prescaler #(
   parameter int DIV = 10000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] count_reg;

   assign tick = en && (count_reg == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (en) begin
         count_reg <= tick ? '0 : count_reg + CNT_W'(1);
      end
   end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear DDS frequency sweep sequencer: start word to stop word, fixed step,
// programmable dwell per step measured in prescaler ticks.
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter int TICK_DIV = 10000,
   parameter int FW_W     = FW_W_DEF,
   parameter int DWELL_W  = DWELL_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   dds_sweep_ctrl_if.slave  bus
);

   sweep_state_t       state_reg;
   logic [FW_W-1:0]    fword_reg;
   logic [FW_W-1:0]    f_start_reg;
   logic [FW_W-1:0]    f_stop_reg;
   logic [FW_W-1:0]    f_step_reg;
   logic [DWELL_W-1:0] dwell_eff_reg;
   logic [DWELL_W-1:0] dwell_cnt_reg;
   logic               repeat_reg;
   logic               dir_up_reg;
   logic               fword_valid_reg;
   logic               busy_reg;
   logic               done_reg;

   logic               in_dwell;
   logic               tick;
   logic               at_end;
   logic [FW_W:0]      sum_up;
   logic [FW_W-1:0]    gap_down;
   logic [FW_W-1:0]    step_next;

   assign in_dwell = (state_reg == ST_DWELL);

   // Prescaler is held clear outside DWELL, so every entry starts a fresh tick period.
   tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (in_dwell),
      .clr  (!in_dwell),
      .tick (tick)
   );

   assign at_end = (fword_reg == f_stop_reg) || (f_step_reg == '0);

   // Clamp to the stop word instead of overshooting; the extra sum bit catches carry-out.
   always_comb begin
      sum_up    = {1'b0, fword_reg} + {1'b0, f_step_reg};
      gap_down  = fword_reg - f_stop_reg;
      step_next = fword_reg;
      if (dir_up_reg) begin
         if (sum_up >= {1'b0, f_stop_reg}) step_next = f_stop_reg;
         else                              step_next = sum_up[FW_W-1:0];
      end else begin
         if (f_step_reg > gap_down) step_next = f_stop_reg;
         else                       step_next = fword_reg - f_step_reg;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         fword_reg       <= '0;
         f_start_reg     <= '0;
         f_stop_reg      <= '0;
         f_step_reg      <= '0;
         dwell_eff_reg   <= '0;
         dwell_cnt_reg   <= '0;
         repeat_reg      <= 1'b0;
         dir_up_reg      <= 1'b0;
         fword_valid_reg <= 1'b0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         fword_valid_reg <= 1'b0;
         done_reg        <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (bus.start && !bus.stop) begin
                  f_start_reg     <= bus.f_start;
                  f_stop_reg      <= bus.f_stop;
                  f_step_reg      <= bus.f_step;
                  dwell_eff_reg   <= (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
                  repeat_reg      <= bus.repeat_en;
                  dir_up_reg      <= (bus.f_stop >= bus.f_start);
                  fword_reg       <= bus.f_start;
                  fword_valid_reg <= 1'b1;
                  dwell_cnt_reg   <= '0;
                  busy_reg        <= 1'b1;
                  state_reg       <= ST_DWELL;
               end
            end
            ST_DWELL: begin
               if (bus.stop) begin
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end else if (tick) begin
                  if (dwell_cnt_reg == dwell_eff_reg - DWELL_W'(1)) begin
                     dwell_cnt_reg <= '0;
                     state_reg     <= ST_STEP;
                  end else begin
                     dwell_cnt_reg <= dwell_cnt_reg + DWELL_W'(1);
                  end
               end
            end
            ST_STEP: begin
               if (bus.stop) begin
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end else if (at_end) begin
                  if (repeat_reg) begin
                     fword_reg       <= f_start_reg;
                     fword_valid_reg <= 1'b1;
                     state_reg       <= ST_DWELL;
                  end else begin
                     done_reg  <= 1'b1;
                     state_reg <= ST_DONE;
                  end
               end else begin
                  fword_reg       <= step_next;
                  fword_valid_reg <= 1'b1;
                  state_reg       <= ST_DWELL;
               end
            end
            ST_DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.fword       = fword_reg;
   assign bus.fword_valid = fword_valid_reg;
   assign bus.busy        = busy_reg;
   assign bus.done        = done_reg;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: fixed vectors, hand-written corner sequences and
// randomized sweeps checked against a list-based model of the sweep.
module tb_dds_sweep_ctrl;
   import dds_pkg::*;

   localparam int DIV = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;

   logic [31:0] upd_val[$];
   int          upd_cyc[$];
   int          done_cyc[$];
   logic [31:0] exp_q[$];

   typedef struct {
      string       name;
      logic [31:0] fs, fe, st;
      logic [15:0] dw;
      int          p;
      int          n;
      logic [3:0][31:0] w;
   } vec_t;
   vec_t tbl[7];

   dds_sweep_ctrl_if #(.FW_W(32), .DWELL_W(16)) bus ();

   dds_sweep_ctrl #(.TICK_DIV(DIV), .FW_W(32), .DWELL_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.fword_valid) begin
         upd_val.push_back(bus.fword);
         upd_cyc.push_back(cyc);
      end
      if (bus.done) done_cyc.push_back(cyc);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic set_vec(input int i, input string name, input logic [31:0] fs, fe, st,
                          input logic [15:0] dw, input int p, input int n,
                          input logic [31:0] w0, w1, w2, w3);
      tbl[i].name = name; tbl[i].fs = fs; tbl[i].fe = fe; tbl[i].st = st;
      tbl[i].dw = dw; tbl[i].p = p; tbl[i].n = n;
      tbl[i].w[0] = w0; tbl[i].w[1] = w1; tbl[i].w[2] = w2; tbl[i].w[3] = w3;
   endtask

   // Expected word list from plain arithmetic: every start+k*step short of the stop, then the stop.
   function automatic void model_words(input logic [31:0] fs, fe, st);
      longint v;
      exp_q.delete();
      if (st == 0 || fs == fe) begin
         exp_q.push_back(fs);
      end else if (fe > fs) begin
         for (v = longint'(fs); v < longint'(fe); v += longint'(st)) exp_q.push_back(v[31:0]);
         exp_q.push_back(fe);
      end else begin
         for (v = longint'(fs); v > longint'(fe); v -= longint'(st)) exp_q.push_back(v[31:0]);
         exp_q.push_back(fe);
      end
   endfunction

   task automatic cfg(input logic [31:0] fs, fe, st, input logic [15:0] dw, input logic rep);
      bus.f_start = fs; bus.f_stop = fe; bus.f_step = st; bus.dwell = dw; bus.repeat_en = rep;
   endtask

   // One non-repeating sweep; optionally disturbs the inputs and re-pulses start mid-sweep.
   task automatic run_sweep(input string name, input logic [31:0] fs, fe, st,
                            input logic [15:0] dw, input int p, input bit disturb);
      int base_u, base_d, t0, guard, n_got, n_exp;
      base_u = upd_val.size();
      base_d = done_cyc.size();
      cfg(fs, fe, st, dw, 1'b0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      t0 = cyc;
      if (disturb) begin
         repeat (2) @(negedge clk);
         cfg($urandom, $urandom, $urandom, 16'($urandom), 1'b1);
         bus.start = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
      end
      guard = 0;
      while (bus.busy && guard < 4000) begin
         @(negedge clk);
         guard++;
      end
      n_exp = exp_q.size();
      n_got = upd_val.size() - base_u;
      chk({name, "_timeout"}, 64'(guard < 4000), 64'(1));
      chk({name, "_nupd"}, 64'(n_got), 64'(n_exp));
      for (int k = 0; k < n_exp && k < n_got; k++) begin
         chk($sformatf("%s_val%0d", name, k), 64'(upd_val[base_u+k]), 64'(exp_q[k]));
         chk($sformatf("%s_cyc%0d", name, k), 64'(upd_cyc[base_u+k] - t0), 64'(k * p));
      end
      chk({name, "_ndone"}, 64'(done_cyc.size() - base_d), 64'(1));
      if (done_cyc.size() > base_d)
         chk({name, "_done_cyc"}, 64'(done_cyc[base_d] - t0), 64'(n_exp * p));
      chk({name, "_busy_low_cyc"}, 64'(cyc - t0), 64'(n_exp * p + 1));
      $display("sweep %s: start=%0h stop=%0h step=%0h dwell=%0d updates=%0d", name, fs, fe, st, dw, n_got);
      @(negedge clk);
   endtask

   initial begin
      int base_u, base_d, t0, p;
      logic [31:0] held, fs, fe, st, span;
      logic [15:0] dw;

      bus.start = 1'b0; bus.stop = 1'b0;
      cfg(32'd0, 32'd0, 32'd0, 16'd0, 1'b0);

      set_vec(0, "up",       32'd100,        32'd130,        32'd10,   16'd2, 9, 4, 32'd100, 32'd110, 32'd120, 32'd130);
      set_vec(1, "clamp",    32'd100,        32'd125,        32'd10,   16'd2, 9, 4, 32'd100, 32'd110, 32'd120, 32'd125);
      set_vec(2, "down",     32'd50,         32'd20,         32'd20,   16'd2, 9, 3, 32'd50,  32'd30,  32'd20,  32'd0);
      set_vec(3, "step0",    32'd77,         32'd200,        32'd0,    16'd1, 5, 1, 32'd77,  32'd0,   32'd0,   32'd0);
      set_vec(4, "dwell0",   32'd100,        32'd130,        32'd10,   16'd0, 5, 4, 32'd100, 32'd110, 32'd120, 32'd130);
      set_vec(5, "overflow", 32'hFFFF_FFF0,  32'hFFFF_FFFF,  32'h20,   16'd1, 5, 2, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd0, 32'd0);
      set_vec(6, "equal",    32'd5,          32'd5,          32'd3,    16'd1, 5, 1, 32'd5,   32'd0,   32'd0,   32'd0);

      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("rst_fword", 64'(bus.fword), 64'(0));
      chk("rst_valid", 64'(bus.fword_valid), 64'(0));
      chk("rst_busy_after", 64'(bus.busy), 64'(0));
      chk("rst_done", 64'(bus.done), 64'(0));

      for (int i = 0; i < 7; i++) begin
         exp_q.delete();
         for (int k = 0; k < tbl[i].n; k++) exp_q.push_back(tbl[i].w[k]);
         run_sweep(tbl[i].name, tbl[i].fs, tbl[i].fe, tbl[i].st, tbl[i].dw, tbl[i].p, (i % 2) == 1);
      end

      // start and stop together from IDLE: nothing happens
      held = bus.fword;
      base_u = upd_val.size();
      cfg(32'd1, 32'd9, 32'd1, 16'd1, 1'b0);
      bus.start = 1'b1; bus.stop = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.stop = 1'b0;
      repeat (2) @(negedge clk);
      chk("startstop_busy", 64'(bus.busy), 64'(0));
      chk("startstop_fword", 64'(bus.fword), 64'(held));
      chk("startstop_nupd", 64'(upd_val.size() - base_u), 64'(0));
      $display("seq start+stop: busy=%0d fword=%0h", bus.busy, bus.fword);

      // repeating sweep, then stop in the middle of a dwell
      base_u = upd_val.size();
      base_d = done_cyc.size();
      cfg(32'd0, 32'd2, 32'd1, 16'd1, 1'b1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      t0 = cyc;
      while (cyc < t0 + 37) @(negedge clk);
      chk("rep_nupd", 64'(upd_val.size() - base_u), 64'(8));
      for (int k = 0; k < 8 && base_u + k < upd_val.size(); k++) begin
         chk($sformatf("rep_val%0d", k), 64'(upd_val[base_u+k]), 64'(k % 3));
         chk($sformatf("rep_cyc%0d", k), 64'(upd_cyc[base_u+k] - t0), 64'(k * 5));
      end
      chk("rep_ndone", 64'(done_cyc.size() - base_d), 64'(0));
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      chk("rep_stop_busy", 64'(bus.busy), 64'(0));
      chk("rep_stop_fword", 64'(bus.fword), 64'(1));
      repeat (10) @(negedge clk);
      chk("rep_stop_nupd", 64'(upd_val.size() - base_u), 64'(8));
      chk("rep_stop_ndone", 64'(done_cyc.size() - base_d), 64'(0));
      $display("seq repeat+stop: fword=%0h busy=%0d", bus.fword, bus.busy);

      // stop landing in the STEP cycle beats the step update
      base_u = upd_val.size();
      base_d = done_cyc.size();
      cfg(32'd10, 32'd50, 32'd10, 16'd1, 1'b0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      chk("stopstep_busy", 64'(bus.busy), 64'(0));
      chk("stopstep_fword", 64'(bus.fword), 64'(10));
      repeat (6) @(negedge clk);
      chk("stopstep_nupd", 64'(upd_val.size() - base_u), 64'(1));
      chk("stopstep_ndone", 64'(done_cyc.size() - base_d), 64'(0));
      $display("seq stop-in-step: fword=%0h busy=%0d", bus.fword, bus.busy);

      // asynchronous reset mid-dwell, observed before any clock edge
      cfg(32'd100, 32'd130, 32'd10, 16'd2, 1'b0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_fword", 64'(bus.fword), 64'(0));
      chk("arst_busy", 64'(bus.busy), 64'(0));
      chk("arst_valid", 64'(bus.fword_valid), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      $display("seq async reset: fword=%0h busy=%0d", bus.fword, bus.busy);
      exp_q.delete();
      for (int k = 0; k < tbl[0].n; k++) exp_q.push_back(tbl[0].w[k]);
      run_sweep("after_rst", tbl[0].fs, tbl[0].fe, tbl[0].st, tbl[0].dw, tbl[0].p, 1'b0);

      for (int r = 0; r < 10; r++) begin
         fs = $urandom;
         if ($urandom_range(0, 2) == 0) fs = 32'hFFFF_FFFF - 32'($urandom_range(0, 50));
         if ($urandom_range(0, 2) == 0) fs = 32'($urandom_range(0, 50));
         span = 32'($urandom_range(0, 90));
         if ($urandom_range(0, 1) == 1) fe = (fs > 32'hFFFF_FFFF - span) ? 32'hFFFF_FFFF : fs + span;
         else                           fe = (fs < span) ? 32'd0 : fs - span;
         st = 32'($urandom_range(0, 40));
         dw = 16'($urandom_range(0, 3));
         p  = ((dw == 0) ? 1 : int'(dw)) * DIV + 1;
         model_words(fs, fe, st);
         run_sweep($sformatf("rnd%0d", r), fs, fe, st, dw, p, $urandom_range(0, 1) == 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
